// File: rtl/sa_pkg.sv
// sa_pkg: shared FSM encoding, default width macros and beat-counter width helper (optional DRAIN_STALL_CNT_EN lives in the top)
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef ARRAYHEIGHT
`define ARRAYHEIGHT 4
`endif
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 16
`endif
package sa_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
  function automatic int cnt_w(input int h);
    return $clog2(h + 1);
  endfunction
  localparam int CNT_W = cnt_w(`ARRAYHEIGHT);
endpackage

// File: rtl/drain_beat_counter.sv
// drain_beat_counter: clear/enable beat counter with terminal count at H; ports clk, rst, clr, en -> cnt, tc
module drain_beat_counter #(
  parameter int H = 4,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb begin
    tc    = en && (cnt_q == W'(H - 1));
    cnt_d = (clr || tc) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/output_drain_ctrl.sv
// output_drain_ctrl: loads ARRAY_H result rows into the shift-register bank, drains them to the output buffer (ports: start/base_addr/res_valid in, load_en/out_en to shifters, sr_out in, wr_en/wr_addr/wr_data out, busy/done status, stall_cnt when DRAIN_STALL_CNT_EN)
module output_drain_ctrl
  import sa_pkg::*;
#(
  parameter int ARRAY_W = `ARRAYWIDTH,
  parameter int ARRAY_H = `ARRAYHEIGHT,
  parameter int DATA_W  = `OUTPUT_BUF_DATASIZE,
  parameter int ADDR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic                      res_valid,
  output logic                      load_en,
  output logic                      out_en,
  input  logic [ARRAY_W*DATA_W-1:0] sr_out,
  input  logic                      wr_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [ARRAY_W*DATA_W-1:0] wr_data,
  output logic                      busy,
`ifdef DRAIN_STALL_CNT_EN
  output logic [15:0]               stall_cnt,
`endif
  output logic                      done
);
  localparam int CW = cnt_w(ARRAY_H);
  state_e            state_d, state_q;
  logic [ADDR_W-1:0] base_d, base_q;
  logic [CW-1:0]     cnt;
  logic              tc, clr, en;
  drain_beat_counter #(.H(ARRAY_H), .W(CW)) u_cnt (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .cnt(cnt), .tc(tc)
  );
  always_comb begin
    load_en = (state_q == LOAD) && res_valid;
    wr_en   = (state_q == DRAIN) && wr_ready;
    out_en  = wr_en;
    wr_data = wr_en ? sr_out : '0;
    wr_addr = (state_q == DRAIN) ? base_q + ADDR_W'(cnt) : '0;
    busy    = (state_q == LOAD) || (state_q == DRAIN);
    done    = state_q == DONE;
    clr     = (state_q == IDLE) && start;
    en      = load_en || wr_en;
    base_d  = clr ? base_addr : base_q;
    state_d = clr ? LOAD :
              (tc && state_q == LOAD)  ? DRAIN :
              (tc && state_q == DRAIN) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end
`ifdef DRAIN_STALL_CNT_EN
  logic [15:0] stall_d, stall_q;
  always_comb stall_d = clr ? '0 :
                        ((state_q == DRAIN) && !wr_ready && stall_q != 16'hFFFF) ? stall_q + 1'b1 : stall_q;
  always_ff @(posedge clk) stall_q <= rst ? '0 : stall_d;
  assign stall_cnt = stall_q;
`endif
endmodule
